// File: rtl/julia_pkg.sv
// Shared types and bus constants for the pixel writer path.
package julia_pkg;

    localparam int unsigned PIX_ADDR_W  = 32;
    localparam int unsigned PIX_COLOR_W = 8;
    localparam int unsigned BUS_DATA_W  = 32;
    localparam int unsigned BUS_BE_W    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } pixel_writer_state_t;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0]  addr;
        logic [PIX_COLOR_W-1:0] color;
    } pixel_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel entries; pointers carry an extra wrap bit for full/empty.
module pixel_fifo
    import julia_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic         pop,
    input  pixel_entry_t wdata,
    output pixel_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pixel_entry_t     mem_q [DEPTH];
    logic [CNT_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Status flags and gated handshakes; a full FIFO refuses pushes even with a concurrent pop.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + CNT_W'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + CNT_W'(1) : rd_q;
        rdata   = mem_q[rd_q[PTR_W-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers rendered pixels and drains them as single-byte writes on a 32-bit master port.
module pixel_writer
    import julia_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COLOR_W = PIX_COLOR_W,
    parameter int unsigned ADDR_W  = PIX_ADDR_W
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [COLOR_W-1:0]    in_color,
    output logic                  m_write,
    output logic [ADDR_W-1:0]     m_address,
    output logic [BUS_DATA_W-1:0] m_writedata,
    output logic [BUS_BE_W-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic                  clear_count,
    output logic [31:0]           pixel_count,
    output logic                  idle
);

    pixel_writer_state_t   state_q, state_d;
    logic                  m_write_q, m_write_d;
    logic [ADDR_W-1:0]     m_address_q, m_address_d;
    logic [BUS_DATA_W-1:0] m_writedata_q, m_writedata_d;
    logic [BUS_BE_W-1:0]   m_byteenable_q, m_byteenable_d;
    logic [31:0]           pixel_count_q, pixel_count_d;

    pixel_entry_t fifo_wdata;
    pixel_entry_t fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic         complete;

    assign fifo_wdata = '{addr: in_addr, color: in_color};

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, pop decision and output-register loads.
    always_comb begin
        state_d        = state_q;
        m_write_d      = m_write_q;
        m_address_d    = m_address_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;
        fifo_pop       = 1'b0;
        complete       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    m_write_d = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    complete = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        m_write_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                m_write_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (fifo_pop) begin
            m_address_d    = {fifo_head.addr[ADDR_W-1:2], 2'b00};
            m_byteenable_d = BUS_BE_W'(4'b0001 << fifo_head.addr[1:0]);
            m_writedata_d  = {4{fifo_head.color}};
        end

        if (clear_count) begin
            pixel_count_d = '0;
        end else if (complete) begin
            pixel_count_d = pixel_count_q + 32'd1;
        end else begin
            pixel_count_d = pixel_count_q;
        end
    end

    // State, bus output and counter registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
            pixel_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
            pixel_count_q  <= pixel_count_d;
        end
    end

    assign in_ready     = !fifo_full;
    assign idle         = (state_q == IDLE) && fifo_empty;
    assign m_write      = m_write_q;
    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_byteenable = m_byteenable_q;
    assign pixel_count  = pixel_count_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single writes, lane select, stall, backpressure, reset, clear.
module tb_pixel_writer;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [7:0]  in_color;
    logic        m_write;
    logic [31:0] m_address;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic        clear_count;
    logic [31:0] pixel_count;
    logic        idle;

    int vectors;
    int miscompares;

    pixel_writer #(
        .DEPTH   (4),
        .COLOR_W (8),
        .ADDR_W  (32)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_color      (in_color),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .clear_count   (clear_count),
        .pixel_count   (pixel_count),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel through an idle block with waitrequest low: accept, pop, complete.
    task automatic send_one(input logic [31:0] addr, input logic [7:0] color,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_cnt);
        in_valid = 1'b1;
        in_addr  = addr;
        in_color = color;
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_no_write", 32'(m_write), 32'd0);
        chk("accept_not_idle", 32'(idle), 32'd0);
        @(negedge clk);
        chk("pop_write", 32'(m_write), 32'd1);
        chk("pop_address", m_address, exp_addr);
        chk("pop_byteenable", 32'(m_byteenable), 32'(exp_be));
        chk("pop_writedata", m_writedata, exp_wd);
        chk("pop_count", pixel_count, exp_cnt - 32'd1);
        @(negedge clk);
        chk("done_write", 32'(m_write), 32'd0);
        chk("done_count", pixel_count, exp_cnt);
        chk("done_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        n_rst         = 1'b0;
        in_valid      = 1'b0;
        in_addr       = '0;
        in_color      = '0;
        m_waitrequest = 1'b0;
        clear_count   = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_m_byteenable", 32'(m_byteenable), 32'd0);
        chk("rst_pixel_count", pixel_count, 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        n_rst = 1'b1;
        @(negedge clk);

        // Single pixel and lane selects
        send_one(32'h0000_03E8, 8'hA5, 32'h0000_03E8, 4'b0001, 32'hA5A5_A5A5, 32'd1);
        send_one(32'h0000_03EA, 8'h3C, 32'h0000_03E8, 4'b0100, 32'h3C3C_3C3C, 32'd2);
        send_one(32'h0000_1803, 8'h11, 32'h0000_1800, 4'b1000, 32'h1111_1111, 32'd3);

        // Stall: waitrequest high for 3 edges keeps the bus frozen for 4 cycles
        m_waitrequest = 1'b1;
        in_valid = 1'b1;
        in_addr  = 32'h0000_2001;
        in_color = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("stall_write", 32'(m_write), 32'd1);
            chk("stall_address", m_address, 32'h0000_2000);
            chk("stall_byteenable", 32'(m_byteenable), 32'h2);
            chk("stall_writedata", m_writedata, 32'h7777_7777);
            chk("stall_count", pixel_count, 32'd3);
            if (i < 3) @(negedge clk);
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_done_write", 32'(m_write), 32'd0);
        chk("stall_done_count", pixel_count, 32'd4);

        // Clear counter while idle
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        chk("clear_idle", pixel_count, 32'd0);

        // Backpressure: 6 offers under stall, only DEPTH+1 accepted
        m_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h0000_4000 + 32'(4 * i);
            in_color = 8'h10 + 8'(i);
            chk("bp_in_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_head_address", m_address, 32'h0000_4000);
        m_waitrequest = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_write", 32'(m_write), 32'd1);
            chk("bp_drain_address", m_address, 32'h0000_4000 + 32'(4 * k));
            chk("bp_drain_writedata", m_writedata, {4{8'h10 + 8'(k)}});
            chk("bp_drain_count", pixel_count, 32'(k));
            @(negedge clk);
        end
        chk("bp_done_write", 32'(m_write), 32'd0);
        chk("bp_done_count", pixel_count, 32'd5);
        chk("bp_done_ready", 32'(in_ready), 32'd1);

        // Reset with a stalled write and 3 buffered pixels
        m_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 32'h0000_5000 + 32'(4 * i);
            in_color = 8'h50 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_write", 32'(m_write), 32'd1);
        chk("pre_rst_idle", 32'(idle), 32'd0);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        m_waitrequest = 1'b0;
        chk("mid_rst_write", 32'(m_write), 32'd0);
        chk("mid_rst_address", m_address, 32'd0);
        chk("mid_rst_writedata", m_writedata, 32'd0);
        chk("mid_rst_byteenable", 32'(m_byteenable), 32'd0);
        chk("mid_rst_count", pixel_count, 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_write", 32'(m_write), 32'd0);
            chk("post_rst_count", pixel_count, 32'd0);
        end

        // Clear coinciding with a completion wins, next completion counts 1
        send_one(32'h0000_0100, 8'hEE, 32'h0000_0100, 4'b0001, 32'hEEEE_EEEE, 32'd1);
        in_valid = 1'b1;
        in_addr  = 32'h0000_0105;
        in_color = 8'h42;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_pop_write", 32'(m_write), 32'd1);
        chk("clr_pop_count", pixel_count, 32'd1);
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        chk("clr_same_edge_count", pixel_count, 32'd0);
        chk("clr_same_edge_write", 32'(m_write), 32'd0);
        send_one(32'h0000_0202, 8'h99, 32'h0000_0200, 4'b0100, 32'h9999_9999, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
